// File: rtl/sccb_write_scheduler_if.sv
// Bus bundle between the two command requesters, the write scheduler and the SCCB master.
// The slave modport is the scheduler's view; the master modport is the requesters'/bus side.
interface sccb_write_scheduler_if;
    logic        cfg_valid;
    logic [15:0] cfg_cmd;
    logic        cfg_ready;
    logic        rt_valid;
    logic [15:0] rt_cmd;
    logic        rt_ready;
    logic        send;
    logic [7:0]  rega;
    logic [7:0]  value;
    logic        taken;
    logic        busy;
    logic        grant_src;
    logic        timeout_err;

    modport slave (
        input  cfg_valid, cfg_cmd, rt_valid, rt_cmd, taken,
        output cfg_ready, rt_ready, send, rega, value, busy, grant_src, timeout_err
    );

    modport master (
        output cfg_valid, cfg_cmd, rt_valid, rt_cmd, taken,
        input  cfg_ready, rt_ready, send, rega, value, busy, grant_src, timeout_err
    );
endinterface

// File: rtl/sccb_write_scheduler.sv
// Arbitrates boot-config and runtime register writes onto one SCCB master, spacing
// writes by a fixed gap, honouring 16'hFFF0 delay markers and timing out stuck writes.
module sccb_write_scheduler #(
    parameter int GAP_CYCLES     = 16,
    parameter int DELAY_CYCLES   = 50000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    sccb_write_scheduler_if.slave bus
);
    localparam int MAX_A   = (GAP_CYCLES > DELAY_CYCLES) ? GAP_CYCLES : DELAY_CYCLES;
    localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

    // Counter holds "cycles remaining after this one", so each phase loads length-1.
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'((DELAY_CYCLES > 0) ? DELAY_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [15:0]      DELAY_MARKER = 16'hFFF0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        DELAY = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       rega_q, rega_d;
    logic [7:0]       value_q, value_d;
    logic             grant_q, grant_d;
    logic             terr_q, terr_d;
    logic [15:0]      cmd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rega_q  <= 8'h00;
            value_q <= 8'h00;
            grant_q <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rega_q  <= rega_d;
            value_q <= value_d;
            grant_q <= grant_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        rega_d  = rega_q;
        value_d = value_q;
        grant_d = grant_q;
        terr_d  = 1'b0;
        cmd     = bus.cfg_cmd;
        unique case (state_q)
            IDLE: begin
                if ((bus.cfg_valid && bus.cfg_ready) || (bus.rt_valid && bus.rt_ready)) begin
                    grant_d = !bus.cfg_valid;
                    cmd     = bus.cfg_valid ? bus.cfg_cmd : bus.rt_cmd;
                    rega_d  = cmd[15:8];
                    value_d = cmd[7:0];
                    if (cmd == DELAY_MARKER) begin
                        state_d = DELAY;
                        cnt_d   = DLY_LOAD;
                    end else begin
                        state_d = ISSUE;
                        cnt_d   = TO_LOAD;
                    end
                end
            end
            ISSUE: begin
                // A taken arriving on the final timeout cycle counts as success.
                if (bus.taken || cnt_q == '0) begin
                    terr_d = !bus.taken;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end
            end
            GAP, DELAY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        bus.cfg_ready   = (state_q == IDLE) && !rst;
        bus.rt_ready    = (state_q == IDLE) && !rst && !bus.cfg_valid;
        bus.send        = (state_q == ISSUE);
        bus.busy        = (state_q != IDLE);
        bus.rega        = rega_q;
        bus.value       = value_q;
        bus.grant_src   = grant_q;
        bus.timeout_err = terr_q;
    end
endmodule

// File: tb/tb_sccb_write_scheduler.sv
// Directed bench for sccb_write_scheduler: a transaction-level model checked every cycle,
// plus literal expectations for the single-write, contention, delay, timeout and reset cases.
module tb_sccb_write_scheduler;
    localparam int GAP = 16;
    localparam int DLY = 50000;
    localparam int TO  = 100;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   t_n;
    int   t_sends;

    sccb_write_scheduler_if bus_if();

    sccb_write_scheduler #(
        .GAP_CYCLES    (GAP),
        .DELAY_CYCLES  (DLY),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h, want 'h%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 writing, 2 spacing after a write, 3 waiting out a delay marker.
    int         m_mode    = 0;
    int         m_issue_n = 0;
    int         m_left    = 0;
    logic [7:0] m_rega    = 8'h00;
    logic [7:0] m_value   = 8'h00;
    logic       m_grant   = 1'b0;
    logic       m_terr    = 1'b0;
    logic [15:0] m_cmd;

    always_comb m_cmd = bus_if.cfg_valid ? bus_if.cfg_cmd : bus_if.rt_cmd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode    <= 0;
            m_issue_n <= 0;
            m_left    <= 0;
            m_rega    <= 8'h00;
            m_value   <= 8'h00;
            m_grant   <= 1'b0;
            m_terr    <= 1'b0;
        end else begin
            m_terr <= 1'b0;
            case (m_mode)
                0: if (bus_if.cfg_valid || bus_if.rt_valid) begin
                    m_grant <= !bus_if.cfg_valid;
                    m_rega  <= m_cmd[15:8];
                    m_value <= m_cmd[7:0];
                    if (m_cmd == 16'hFFF0) begin
                        m_mode <= 3;
                        m_left <= DLY;
                    end else begin
                        m_mode    <= 1;
                        m_issue_n <= 0;
                    end
                end
                1: if (bus_if.taken || (m_issue_n + 1 == TO)) begin
                    m_terr <= !bus_if.taken;
                    m_mode <= (GAP == 0) ? 0 : 2;
                    m_left <= GAP;
                end else begin
                    m_issue_n <= m_issue_n + 1;
                end
                default: begin
                    if (m_left == 1) m_mode <= 0;
                    m_left <= m_left - 1;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        check("cycle_outputs",
              {10'd0, bus_if.send, bus_if.busy, bus_if.cfg_ready, bus_if.rt_ready,
               bus_if.grant_src, bus_if.timeout_err, bus_if.rega, bus_if.value},
              {10'd0, m_mode == 1, m_mode != 0, (m_mode == 0) && !rst,
               (m_mode == 0) && !rst && !bus_if.cfg_valid,
               m_grant, m_terr, m_rega, m_value});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (bus_if.busy && n < bound) begin
            step();
            n++;
        end
        check("idle_reached", bus_if.busy, 1'b0);
    endtask

    task automatic issue_cfg(input logic [15:0] c);
        bus_if.cfg_cmd   = c;
        bus_if.cfg_valid = 1'b1;
        step();
        bus_if.cfg_valid = 1'b0;
    endtask

    task automatic pulse_taken();
        bus_if.taken = 1'b1;
        step();
        bus_if.taken = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus_if.cfg_valid = 1'b0;
        bus_if.cfg_cmd   = 16'h0000;
        bus_if.rt_valid  = 1'b0;
        bus_if.rt_cmd    = 16'h0000;
        bus_if.taken     = 1'b0;
        repeat (3) step();
        check("rst_send", bus_if.send, 1'b0);
        check("rst_busy", bus_if.busy, 1'b0);
        check("rst_cfg_ready", bus_if.cfg_ready, 1'b0);
        check("rst_rt_ready", bus_if.rt_ready, 1'b0);
        check("rst_rega", bus_if.rega, 8'h00);
        rst = 1'b0;
        #1;
        check("ready_after_rst", bus_if.cfg_ready, 1'b1);

        // Single write, taken in the fifth ISSUE cycle.
        issue_cfg(16'h1280);
        t_sends = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus_if.send) t_sends++;
            bus_if.taken = (i == 4);
            step();
        end
        bus_if.taken = 1'b0;
        check("w1_send_len", t_sends, 5);
        check("w1_send_drop", bus_if.send, 1'b0);
        check("w1_rega", bus_if.rega, 8'h12);
        check("w1_value", bus_if.value, 8'h80);
        check("model_rega", m_rega, 8'h12);
        t_n = 0;
        while (bus_if.busy && t_n < 100) begin
            t_n++;
            step();
        end
        check("w1_gap_len", t_n, 16);

        // Contention: cfg wins, rt follows after the gap.
        bus_if.cfg_cmd   = 16'hFF01;
        bus_if.cfg_valid = 1'b1;
        bus_if.rt_cmd    = 16'h0C33;
        bus_if.rt_valid  = 1'b1;
        #1;
        check("ct_rt_blocked", bus_if.rt_ready, 1'b0);
        check("ct_cfg_ready", bus_if.cfg_ready, 1'b1);
        step();
        bus_if.cfg_valid = 1'b0;
        check("ct1_grant", bus_if.grant_src, 1'b0);
        check("ct1_rega", bus_if.rega, 8'hFF);
        check("ct1_value", bus_if.value, 8'h01);
        check("ct1_send", bus_if.send, 1'b1);
        pulse_taken();
        wait_idle(100);
        check("ct_rt_ready", bus_if.rt_ready, 1'b1);
        step();
        bus_if.rt_valid = 1'b0;
        check("ct2_grant", bus_if.grant_src, 1'b1);
        check("ct2_rega", bus_if.rega, 8'h0C);
        check("ct2_value", bus_if.value, 8'h33);
        check("ct2_send", bus_if.send, 1'b1);
        pulse_taken();
        wait_idle(100);

        // Delay marker.
        issue_cfg(16'hFFF0);
        t_n = 0;
        t_sends = 0;
        while (bus_if.busy && t_n < 60000) begin
            if (bus_if.send) t_sends++;
            t_n++;
            step();
        end
        check("dly_busy_len", t_n, 50000);
        check("dly_no_send", t_sends, 0);
        bus_if.cfg_cmd   = 16'h1234;
        bus_if.cfg_valid = 1'b1;
        #1;
        check("dly_next_ready", bus_if.cfg_ready, 1'b1);
        step();
        bus_if.cfg_valid = 1'b0;
        check("dly_next_send", bus_if.send, 1'b1);
        check("dly_next_rega", bus_if.rega, 8'h12);
        check("dly_next_value", bus_if.value, 8'h34);
        pulse_taken();
        wait_idle(100);

        // Timeout with taken never asserted.
        issue_cfg(16'h3A55);
        t_n = 0;
        while (bus_if.send && t_n < 200) begin
            t_n++;
            step();
        end
        check("to_issue_len", t_n, 100);
        check("to_err_pulse", bus_if.timeout_err, 1'b1);
        check("to_busy_gap", bus_if.busy, 1'b1);
        step();
        check("to_err_single", bus_if.timeout_err, 1'b0);
        wait_idle(100);

        // Taken on the last timeout cycle wins.
        issue_cfg(16'h3A56);
        for (int i = 1; i <= 100; i++) begin
            bus_if.taken = (i == 100);
            step();
        end
        bus_if.taken = 1'b0;
        check("tk100_send", bus_if.send, 1'b0);
        check("tk100_no_err", bus_if.timeout_err, 1'b0);
        check("tk100_gap", bus_if.busy, 1'b1);
        wait_idle(100);

        // Stray taken in IDLE and in GAP.
        pulse_taken();
        check("stray_idle_send", bus_if.send, 1'b0);
        check("stray_idle_busy", bus_if.busy, 1'b0);
        issue_cfg(16'h4411);
        pulse_taken();
        pulse_taken();
        check("stray_gap_send", bus_if.send, 1'b0);
        t_n = 1;
        while (bus_if.busy && t_n < 100) begin
            t_n++;
            step();
        end
        check("stray_gap_len", t_n, 16);

        // Asynchronous reset mid-ISSUE, then acceptance on the first edge after release.
        issue_cfg(16'h5A5A);
        check("rs_send_before", bus_if.send, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rs_send", bus_if.send, 1'b0);
        check("rs_busy", bus_if.busy, 1'b0);
        check("rs_terr", bus_if.timeout_err, 1'b0);
        check("rs_rega", bus_if.rega, 8'h00);
        check("rs_value", bus_if.value, 8'h00);
        check("rs_ready", bus_if.cfg_ready, 1'b0);
        bus_if.cfg_cmd   = 16'h7711;
        bus_if.cfg_valid = 1'b1;
        step();
        rst = 1'b0;
        step();
        bus_if.cfg_valid = 1'b0;
        check("rs_accept_send", bus_if.send, 1'b1);
        check("rs_accept_rega", bus_if.rega, 8'h77);
        check("rs_accept_value", bus_if.value, 8'h11);
        pulse_taken();
        wait_idle(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sccb_write_scheduler.md
SCCB_WRITE_SCHEDULER -- requirements
Module: sccb_write_scheduler

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 16, meaning idle cycles enforced after each accepted SCCB write.
REQ-002 SHALL have parameter DELAY_CYCLES, default 50000, meaning the wait length for a delay-marker command (1 ms at 50 MHz).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the maximum number of ISSUE cycles spent waiting for taken.
REQ-004 SHALL have port: clk  in  1  50 MHz system clock; single clock domain.
REQ-005 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: cfg_valid in 1, cfg_cmd in 16, cfg_ready out 1 -- boot-configuration requester; cmd[15:8] = register address, cmd[7:0] = data.
REQ-007 SHALL have ports: rt_valid in 1, rt_cmd in 16, rt_ready out 1 -- runtime requester (zoom/exposure tweaks), same format as cfg_cmd.
REQ-008 SHALL have ports: send out 1, rega out 8, value out 8, taken in 1 -- connection to the SCCB/I2C interface.
REQ-009 SHALL have ports: busy out 1 (state != IDLE), grant_src out 1 (0 = cfg, 1 = rt; source of the last accepted command), timeout_err out 1 (single-cycle pulse).

Function
REQ-010 SHALL implement the states IDLE, ISSUE, GAP and DELAY.
REQ-011 SHALL, in IDLE, drive cfg_ready = 1 and rt_ready = ~cfg_valid; in all other states both ready outputs SHALL be 0. Priority is therefore fixed cfg over rt.
REQ-012 SHALL accept a command on a rising edge where valid && ready, latching cmd into rega/value and setting grant_src.
REQ-013 SHALL, when the accepted cmd is not 16'hFFF0, enter ISSUE on the next cycle, with send = 1 held continuously in ISSUE.
REQ-014 SHALL, when the accepted cmd is 16'hFFF0 (delay marker), enter DELAY, keep send = 0 for exactly DELAY_CYCLES cycles, then return to IDLE with no GAP.
REQ-015 SHALL, in ISSUE, on the edge where taken = 1, deassert send on the next cycle and enter GAP.
REQ-016 SHALL ignore taken outside ISSUE.
REQ-017 SHALL keep rega/value stable for the whole of ISSUE and until the next acceptance.
REQ-018 SHALL remain in GAP for exactly GAP_CYCLES cycles, then go to IDLE; if GAP_CYCLES = 0, SHALL go from ISSUE directly to IDLE.
REQ-019 SHALL count ISSUE cycles; after TIMEOUT_CYCLES cycles without taken, SHALL drop send, pulse timeout_err for 1 cycle, and enter GAP.
REQ-020 SHALL let taken win when it is asserted in the same cycle the timeout expires: no timeout_err is raised.
REQ-021 SHALL use one shared counter, wide enough for max(GAP_CYCLES, DELAY_CYCLES, TIMEOUT_CYCLES) (20 bits at the defaults), reloaded on every state entry; the counter SHALL never wrap.
REQ-022 SHALL make the minimum command-to-command spacing 1 (accept) + ISSUE length + GAP_CYCLES cycles; back-to-back requests are never merged or dropped.
REQ-023 SHALL give cfg the next grant whenever cfg_valid and rt_valid are both high in IDLE; rt waits with valid held, and the requester must not change cmd while valid && !ready.

Reset
REQ-024 SHALL, on rst = 1 at any time, immediately force: state IDLE, send = 0, rega = 0, value = 0, grant_src = 0, timeout_err = 0, busy = 0, counter = 0.
REQ-025 SHALL drop an in-flight command on reset mid-ISSUE or mid-DELAY without retry; the requester re-presents it.
REQ-026 SHALL drive ready outputs = 0 while rst is high, and SHALL permit acceptance on the first edge after rst falls.

Verification
REQ-027 Reset: assert rst mid-ISSUE (send = 1) -> send, busy and timeout_err go 0 asynchronously; rega = value = 8'h00.
REQ-028 Single write: cfg_cmd = 16'h1280, valid for 1 cycle; taken pulses 5 cycles later -> send high 5 cycles, rega = 8'h12, value = 8'h80, busy low exactly 16 cycles after send drops.
REQ-029 Contention: cfg_cmd = 16'hFF01 and rt_cmd = 16'h0C33 valid in the same IDLE cycle -> 16'hFF01 issued first (grant_src = 0), then 16'h0C33 (grant_src = 1) after the GAP.
REQ-030 Delay marker: cfg_cmd = 16'hFFF0 -> send stays 0, busy high exactly 50000 cycles, next command accepted on the following cycle.
REQ-031 Timeout: TIMEOUT_CYCLES = 100, taken never asserted -> send drops after 100 ISSUE cycles, a single timeout_err pulse, then GAP and IDLE; taken arriving on cycle 100 -> no timeout_err.
REQ-032 Stray taken: taken pulsed in IDLE and in GAP -> no state change, no send.
